// File: rtl/snoop_bus_arbiter.sv
// Shared-bus arbiter and snoop router for the two-core MSI system.
// It grants the bus round-robin, broadcasts snoops to the other core and selects the fill source.
module snoop_bus_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        read_miss,
  input  logic [1:0]        write_miss,
  input  logic [1:0]        invalidate,
  input  logic [ADDR_W-1:0] bico0,
  input  logic [ADDR_W-1:0] bico1,
  input  logic [1:0]        search_found,
  input  logic [DATA_W-1:0] send_data0,
  input  logic [DATA_W-1:0] send_data1,
  input  logic              u_rdy,
  output logic [1:0]        grant,
  output logic [1:0]        cpu_search,
  output logic [1:0]        inv_other,
  output logic [ADDR_W-1:0] boci0,
  output logic [ADDR_W-1:0] boci1,
  output logic [1:0]        datasel0,
  output logic [1:0]        datasel1,
  output logic [DATA_W-1:0] other_data0,
  output logic [DATA_W-1:0] other_data1,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, SNOOP, RESP, MEMWAIT, DONE} state_t;
  typedef enum logic [1:0] {REQ_RD, REQ_WR, REQ_INV} req_t;

  state_t            state;
  logic [1:0]        pend;
  req_t              type_q [2];
  logic [ADDR_W-1:0] addr_q [2];
  logic              rr_last;
  logic              w_q;
  logic              found_q;
  req_t              cur_type;

  logic [1:0]        pulse;
  logic [1:0]        req;
  req_t              pulse_type [2];
  logic              win;
  logic              oth;
  req_t              win_type;
  logic [ADDR_W-1:0] win_addr;
  logic              snp_found;
  logic [DATA_W-1:0] snp_data;

  // A fresh pulse joins arbitration in the same cycle it arrives.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      pulse[i] = read_miss[i] | write_miss[i] | invalidate[i];
      if (read_miss[i])       pulse_type[i] = REQ_RD;
      else if (write_miss[i]) pulse_type[i] = REQ_WR;
      else                    pulse_type[i] = REQ_INV;
    end
    req       = pend | pulse;
    win       = (req == 2'b11) ? ~rr_last : req[1];
    oth       = ~win;
    win_type  = pend[win] ? type_q[win] : pulse_type[win];
    win_addr  = pend[win] ? addr_q[win] : (win ? bico1 : bico0);
    snp_found = search_found[~w_q];
    snp_data  = w_q ? send_data0 : send_data1;
  end

  // Outputs are registered: each branch loads the values for the state being entered.
  always_ff @(posedge clk) begin
    grant       <= '0;
    cpu_search  <= '0;
    inv_other   <= '0;
    boci0       <= '0;
    boci1       <= '0;
    datasel0    <= '0;
    datasel1    <= '0;
    other_data0 <= '0;
    other_data1 <= '0;
    busy        <= 1'b0;
    if (rst) begin
      state     <= IDLE;
      pend      <= '0;
      type_q[0] <= REQ_RD;
      type_q[1] <= REQ_RD;
      addr_q[0] <= '0;
      addr_q[1] <= '0;
      rr_last   <= 1'b1;
      w_q       <= 1'b0;
      found_q   <= 1'b0;
      cur_type  <= REQ_RD;
    end else begin
      // A same-core pulse in DONE re-arms the slot that is being released.
      for (int unsigned i = 0; i < 2; i++) begin
        if (state == DONE && w_q == 1'(i)) pend[i] <= 1'b0;
        if (pulse[i] && (!pend[i] || (state == DONE && w_q == 1'(i)))) begin
          pend[i]   <= 1'b1;
          type_q[i] <= pulse_type[i];
          addr_q[i] <= (i == 0) ? bico0 : bico1;
        end
      end
      case (state)
        IDLE: begin
          if (|req) begin
            w_q      <= win;
            cur_type <= win_type;
            state    <= SNOOP;
            busy     <= 1'b1;
            if (win) boci0 <= win_addr;
            else     boci1 <= win_addr;
            cpu_search[oth] <= (win_type != REQ_INV);
            inv_other[oth]  <= (win_type != REQ_RD);
          end
        end
        SNOOP: begin
          found_q    <= snp_found;
          state      <= RESP;
          busy       <= 1'b1;
          grant[w_q] <= 1'b1;
          if (cur_type == REQ_RD && snp_found) begin
            if (w_q) begin
              datasel1    <= 2'b01;
              other_data1 <= snp_data;
            end else begin
              datasel0    <= 2'b01;
              other_data0 <= snp_data;
            end
          end
        end
        RESP: begin
          busy <= 1'b1;
          if (cur_type == REQ_RD && !found_q && !u_rdy) begin
            state      <= MEMWAIT;
            grant[w_q] <= 1'b1;
          end else begin
            state <= DONE;
          end
        end
        MEMWAIT: begin
          busy <= 1'b1;
          if (u_rdy) state <= DONE;
          else       grant[w_q] <= 1'b1;
        end
        DONE: begin
          rr_last <= w_q;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Self-checking bench for snoop_bus_arbiter: vector table, hand sequences and random traffic
// compared against a transaction-level reference model.
module tb_snoop_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  read_miss, write_miss, invalidate;
  logic [12:0] bico0, bico1;
  logic [1:0]  search_found;
  logic [15:0] send_data0, send_data1;
  logic        u_rdy;
  logic [1:0]  grant, cpu_search, inv_other;
  logic [12:0] boci0, boci1;
  logic [1:0]  datasel0, datasel1;
  logic [15:0] other_data0, other_data1;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  snoop_bus_arbiter #(.ADDR_W(13), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .read_miss(read_miss), .write_miss(write_miss), .invalidate(invalidate),
    .bico0(bico0), .bico1(bico1), .search_found(search_found),
    .send_data0(send_data0), .send_data1(send_data1), .u_rdy(u_rdy),
    .grant(grant), .cpu_search(cpu_search), .inv_other(inv_other),
    .boci0(boci0), .boci1(boci1), .datasel0(datasel0), .datasel1(datasel1),
    .other_data0(other_data0), .other_data1(other_data1), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: one outstanding request slot per core plus the transaction in flight.
  // phase: 0 bus free, 1 snoop broadcast, 2 first grant cycle, 3 waiting on memory, 4 release
  bit          m_pend [2];
  int          m_type [2];   // 0 read, 1 write, 2 invalidate
  logic [12:0] m_addr [2];
  bit          m_last;
  int          phase;
  bit          cw;
  int          ctype;
  logic [12:0] caddr;
  bit          cfound;
  logic [15:0] cdata;

  task automatic model_step();
    bit pl [2];
    int pt [2];
    bit op [2];
    bit releasing;
    bit rw;
    if (rst) begin
      m_pend = '{0, 0};
      m_last = 1;
      phase  = 0;
      return;
    end
    for (int i = 0; i < 2; i++) begin
      pl[i] = read_miss[i] || write_miss[i] || invalidate[i];
      pt[i] = read_miss[i] ? 0 : (write_miss[i] ? 1 : 2);
      op[i] = m_pend[i];
    end
    releasing = (phase == 4);
    rw = cw;
    case (phase)
      0: if (op[0] || pl[0] || op[1] || pl[1]) begin
        bit r0, r1;
        r0 = op[0] || pl[0];
        r1 = op[1] || pl[1];
        cw = (r0 && r1) ? !m_last : r1;
        ctype = op[cw] ? m_type[cw] : pt[cw];
        caddr = op[cw] ? m_addr[cw] : (cw ? bico1 : bico0);
        phase = 1;
      end
      1: begin
        cfound = search_found[!cw];
        cdata  = cw ? send_data0 : send_data1;
        phase  = 2;
      end
      2: phase = (ctype == 0 && !cfound && !u_rdy) ? 3 : 4;
      3: if (u_rdy) phase = 4;
      default: begin
        m_last = cw;
        phase  = 0;
      end
    endcase
    for (int i = 0; i < 2; i++) begin
      bit mine;
      mine = releasing && (rw == i[0]);
      if (mine) m_pend[i] = 0;
      if (pl[i] && (!op[i] || mine)) begin
        m_pend[i] = 1;
        m_type[i] = pt[i];
        m_addr[i] = (i == 0) ? bico0 : bico1;
      end
    end
  endtask

  function automatic logic [68:0] model_out();
    logic [1:0]  g, cs, io, s0, s1;
    logic [12:0] o0, o1;
    logic [15:0] d0, d1;
    g = 0; cs = 0; io = 0; s0 = 0; s1 = 0; o0 = 0; o1 = 0; d0 = 0; d1 = 0;
    if (phase == 1) begin
      if (cw) o0 = caddr; else o1 = caddr;
      cs[!cw] = (ctype != 2);
      io[!cw] = (ctype != 0);
    end
    if (phase == 2 || phase == 3) g[cw] = 1'b1;
    if (phase == 2 && ctype == 0 && cfound) begin
      if (cw) begin s1 = 2'b01; d1 = cdata; end
      else    begin s0 = 2'b01; d0 = cdata; end
    end
    return {g, cs, io, o0, o1, s0, s1, d0, d1, (phase != 0)};
  endfunction

  function automatic logic [68:0] dut_out();
    return {grant, cpu_search, inv_other, boci0, boci1, datasel0, datasel1,
            other_data0, other_data1, busy};
  endfunction

  task automatic check_val(string name, logic [68:0] act, logic [68:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(string name);
    @(posedge clk);
    model_step();
    #1;
    check_val(name, dut_out(), model_out());
  endtask

  task automatic idle_inputs();
    rst = 0; read_miss = 0; write_miss = 0; invalidate = 0;
    bico0 = 0; bico1 = 0; search_found = 0; send_data0 = 0; send_data1 = 0; u_rdy = 1;
  endtask

  typedef struct {
    logic rst; logic [1:0] rm, wm, iv; logic [12:0] b0, b1; logic [1:0] sf;
    logic [15:0] d0, d1; logic ur;
    logic [1:0] g, cs, io; logic [12:0] o0, o1; logic [1:0] s0, s1;
    logic [15:0] od0, od1; logic bz;
  } vec_t;

  vec_t tbl [$];

  task automatic add(logic r, logic [1:0] rm, logic [1:0] wm, logic [1:0] iv,
                     logic [12:0] b0, logic [12:0] b1, logic [1:0] sf, logic [15:0] d0,
                     logic [15:0] d1, logic ur, logic [1:0] g, logic [1:0] cs,
                     logic [1:0] io, logic [12:0] o0, logic [12:0] o1, logic [1:0] s0,
                     logic [1:0] s1, logic [15:0] od0, logic [15:0] od1, logic bz);
    vec_t v;
    v = '{r, rm, wm, iv, b0, b1, sf, d0, d1, ur, g, cs, io, o0, o1, s0, s1, od0, od1, bz};
    tbl.push_back(v);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick("reset0");
    tick("reset1");

    //  rst rm wm iv  b0     b1     sf d0       d1 ur | g cs io o0     o1     s0 s1 od0 od1      bz
    add(1,  0, 0, 0, 0,      0,     0, 0,       0, 1,   0, 0, 0, 0,     0,     0, 0, 0,  0,       0);
    // core0 read miss served from memory
    add(0,  1, 0, 0, 'h0A4,  0,     0, 0,       0, 1,   0, 2, 0, 0,     'h0A4, 0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 1,   1, 0, 0, 0,     0,     0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 1,   0, 0, 0, 0,     0,     0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 1,   0, 0, 0, 0,     0,     0, 0, 0,  0,       0);
    // core1 read miss, hit-forward from core0
    add(0,  2, 0, 0, 0,      'h1F3, 1, 'hBEEF,  0, 1,   0, 1, 0, 'h1F3, 0,     0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     1, 'hBEEF,  0, 1,   2, 0, 0, 0,     0,     0, 1, 0,  'hBEEF,  1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 1,   0, 0, 0, 0,     0,     0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 1,   0, 0, 0, 0,     0,     0, 0, 0,  0,       0);
    // core0 invalidate, memory never ready
    add(0,  0, 0, 1, 'h040,  0,     0, 0,       0, 0,   0, 0, 2, 0,     'h040, 0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 0,   1, 0, 0, 0,     0,     0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 0,   0, 0, 0, 0,     0,     0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 0,   0, 0, 0, 0,     0,     0, 0, 0,  0,       0);
    // core1 read miss, memory slow for five cycles
    add(0,  2, 0, 0, 0,      'h155, 0, 0,       0, 0,   0, 1, 0, 'h155, 0,     0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 0,   2, 0, 0, 0,     0,     0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 0,   2, 0, 0, 0,     0,     0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 0,   2, 0, 0, 0,     0,     0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 0,   2, 0, 0, 0,     0,     0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 1,   0, 0, 0, 0,     0,     0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 1,   0, 0, 0, 0,     0,     0, 0, 0,  0,       0);
    // core1 write miss: search and invalidate, found data ignored
    add(0,  0, 2, 0, 0,      'h077, 1, 'h1234,  0, 0,   0, 1, 1, 'h077, 0,     0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     1, 'h1234,  0, 0,   2, 0, 0, 0,     0,     0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 0,   0, 0, 0, 0,     0,     0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 0,   0, 0, 0, 0,     0,     0, 0, 0,  0,       0);
    // reset during memory wait, then a fresh core1 request
    add(0,  1, 0, 0, 'h111,  0,     0, 0,       0, 0,   0, 2, 0, 0,     'h111, 0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 0,   1, 0, 0, 0,     0,     0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 0,   1, 0, 0, 0,     0,     0, 0, 0,  0,       1);
    add(1,  0, 0, 0, 0,      0,     0, 0,       0, 0,   0, 0, 0, 0,     0,     0, 0, 0,  0,       0);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 0,   0, 0, 0, 0,     0,     0, 0, 0,  0,       0);
    add(0,  2, 0, 0, 0,      'h0AB, 0, 0,       0, 1,   0, 1, 0, 'h0AB, 0,     0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 1,   2, 0, 0, 0,     0,     0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 1,   0, 0, 0, 0,     0,     0, 0, 0,  0,       1);
    add(0,  0, 0, 0, 0,      0,     0, 0,       0, 1,   0, 0, 0, 0,     0,     0, 0, 0,  0,       0);

    for (int k = 0; k < tbl.size(); k++) begin
      rst = tbl[k].rst; read_miss = tbl[k].rm; write_miss = tbl[k].wm; invalidate = tbl[k].iv;
      bico0 = tbl[k].b0; bico1 = tbl[k].b1; search_found = tbl[k].sf;
      send_data0 = tbl[k].d0; send_data1 = tbl[k].d1; u_rdy = tbl[k].ur;
      tick($sformatf("tbl%0d_model", k));
      check_val($sformatf("tbl%0d", k), dut_out(),
                {tbl[k].g, tbl[k].cs, tbl[k].io, tbl[k].o0, tbl[k].o1, tbl[k].s0, tbl[k].s1,
                 tbl[k].od0, tbl[k].od1, tbl[k].bz});
    end

    // Simultaneous requests after reset: core0 first, core1 after release.
    idle_inputs();
    rst = 1; tick("rr_reset");
    rst = 0; read_miss = 2'b11; bico0 = 'h010; bico1 = 'h020;
    tick("rr_a_snoop");  check_val("rr_a_first_cs", 69'(cpu_search), 69'(2'b10));
    read_miss = 0;
    tick("rr_a_resp");   check_val("rr_a_first_grant", 69'(grant), 69'(2'b01));
    tick("rr_a_done");
    tick("rr_a_idle");   check_val("rr_a_gap_busy", 69'(busy), 69'(1'b0));
    tick("rr_a_snoop2"); check_val("rr_a_second_boci0", 69'(boci0), 69'('h020));
    tick("rr_a_resp2");  check_val("rr_a_second_grant", 69'(grant), 69'(2'b10));
    tick("rr_a_done2");
    tick("rr_a_idle2");
    // core0 served alone, so the next tie goes to core1
    read_miss = 2'b01;
    tick("rr_b_snoop"); read_miss = 0;
    for (int i = 0; i < 3; i++) tick("rr_b_run");
    read_miss = 2'b11;
    tick("rr_c_snoop");  check_val("rr_c_first_cs", 69'(cpu_search), 69'(2'b01));
    read_miss = 0;
    tick("rr_c_resp");   check_val("rr_c_first_grant", 69'(grant), 69'(2'b10));
    for (int i = 0; i < 6; i++) tick("rr_c_run");

    // Pulse ignored while pending, pulse during release re-arms.
    read_miss = 2'b01; bico0 = 'h0AA;
    tick("rearm_snoop");
    bico0 = 'h0EE;
    tick("rearm_dup_ignored");
    read_miss = 0;
    tick("rearm_done");
    read_miss = 2'b01; bico0 = 'h0CC;
    tick("rearm_pulse_in_done");  check_val("rearm_idle_busy", 69'(busy), 69'(1'b0));
    read_miss = 0;
    tick("rearm_snoop2");         check_val("rearm_boci1", 69'(boci1), 69'('h0CC));
    for (int i = 0; i < 3; i++) tick("rearm_run");
    tick("rearm_quiet");          check_val("rearm_no_dup", 69'(busy), 69'(1'b0));

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(199) == 0);
      read_miss    = {($urandom_range(9) == 0), ($urandom_range(9) == 0)};
      write_miss   = {($urandom_range(9) == 0), ($urandom_range(9) == 0)};
      invalidate   = {($urandom_range(9) == 0), ($urandom_range(9) == 0)};
      bico0        = 13'($urandom);
      bico1        = 13'($urandom);
      search_found = 2'($urandom);
      send_data0   = 16'($urandom);
      send_data1   = 16'($urandom);
      u_rdy        = ($urandom_range(9) < 6);
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
- Shared-bus arbiter and snoop router for the two-core MSI system. It sits between the two per-core cache controllers and the unified data memory.
- It latches miss/invalidate pulses from each controller and grants the bus round-robin.
- It broadcasts the winner's address to the other core as a snoop and routes forwarded data back.
- It tells the winner whether to fill its line from the other core or from memory.

Parameters:
- ADDR_W, 13, word address width (matches the controller's BICO/BOCI).
- DATA_W, 16, forwarded word width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- read_miss  in  2  per-core read-miss pulse, bit i = core i
- write_miss  in  2  per-core write-miss pulse
- invalidate  in  2  per-core upgrade (SHARED->MODIFIED) invalidate pulse
- bico0  in  ADDR_W  core0 bus address, valid with its pulse
- bico1  in  ADDR_W  core1 bus address
- search_found  in  2  snoop-hit response from core i
- send_data0  in  DATA_W  core0 snooped word
- send_data1  in  DATA_W  core1 snooped word
- u_rdy  in  1  unified memory ready
- grant  out  2  bus grant to core i
- cpu_search  out  2  snoop-search request to core i
- inv_other  out  2  invalidate_from_other_cpu to core i
- boci0  out  ADDR_W  snoop address to core0
- boci1  out  ADDR_W  snoop address to core1
- datasel0  out  2  core0 fill source: 00 = dmem, 01 = other proc
- datasel1  out  2  core1 fill source
- other_data0  out  DATA_W  forwarded word to core0
- other_data1  out  DATA_W  forwarded word to core1
- busy  out  1  transaction in progress

Behaviour:
- **Clock and reset.** Single clock domain. Synchronous reset: state = IDLE; pend, type, addr, found and fwd_data registers cleared; rr_last = 1, so core0 has first priority. All outputs are 0 in reset and IDLE.
- **Request capture.**
  - Any pulse bit i sets pend[i] and latches the type (priority RD > WR > INV if several bits are set together) and bico_i into addr_q[i].
  - A pulse for core i while pend[i] = 1 is ignored.
  - Clearing pend[w] in DONE and a new pulse from the same core in the same cycle: the pulse wins and re-arms.
- **Arbitration.**
  - Effective request = pend | (pulse bits), so a pulse arriving in IDLE is arbitrated in that same cycle.
  - Both requesting: winner w = ~rr_last. Otherwise the single requester wins.
  - o denotes the other core.
- **FSM states:** IDLE, SNOOP, RESP, MEMWAIT, DONE.
  - **IDLE:** any effective request -> SNOOP; capture w, type and addr. busy = 0.
  - **SNOOP** (1 cycle): boci_o = addr.
    - RD or WR: cpu_search[o] = 1.
    - WR or INV: inv_other[o] = 1.
    - Sample search_found[o] and send_data_o into found and fwd_data.
    - Next state: RESP.
  - **RESP:** grant[w] = 1.
    - RD with found: datasel_w = 01, other_data_w = fwd_data -> DONE.
    - RD without found: datasel_w = 00; if u_rdy -> DONE, else -> MEMWAIT.
    - WR and INV: datasel_w = 00 -> DONE. The other copy is already invalidated.
  - **MEMWAIT:** grant[w] = 1, datasel_w = 00; stay until u_rdy = 1 -> DONE. No timeout.
  - **DONE** (1 cycle): clear pend[w], rr_last = w; grant drops -> IDLE.
- **Output rules.**
  - busy = 1 in SNOOP, RESP, MEMWAIT and DONE.
  - grant is one-hot or zero; it is never asserted to both cores.
  - boci and other_data are 0 whenever not driven.
- **Latency.** Pulse in cycle N with the bus idle: snoop in N+1, grant from N+2. A hit-forward or INV transaction completes at N+3.
- **Reset mid-transaction.** Pending requests are discarded and grant drops the next cycle. Controllers must re-issue.

Test Plan:
1. Reset, then core0 read_miss pulse, bico0 = 0x0A4, search_found[1] = 0, u_rdy = 1 -> cycle+1 cpu_search = 10, boci1 = 0x0A4; cycle+2 grant = 01, datasel0 = 00; idle at +4.
2. Core1 read_miss, bico1 = 0x1F3; core0 returns found = 1, send_data0 = 0xBEEF -> grant = 10, datasel1 = 01, other_data1 = 0xBEEF for one cycle.
3. Both cores pulse read_miss in the same cycle after reset -> core0 is granted first, core1 is granted after DONE. Repeat -> core1 first.
4. Core0 invalidate, bico0 = 0x040 -> inv_other = 10, boci1 = 0x040, cpu_search = 00; grant = 01 one cycle; no u_rdy dependency.
5. Core1 read_miss with memory source, u_rdy low for 5 cycles -> grant[1] held through MEMWAIT, busy = 1; releases the cycle after u_rdy rises.
6. rst asserted during MEMWAIT -> next cycle all outputs 0, pend = 00; a new core1 pulse is served normally.
